game_tick_timer: RTL and testbench

Parametrised tick generator and game timer for the maze game logic. It divides the system clock into a configurable-rate one-cycle `tick` strobe and counts ticks up (elapsed time) or down (time limit). The count is also exposed as two BCD digits. It sits between the board clock and the game FSM / HEX display drivers, replacing the fixed 1 Hz down-counter and its separate elapsed-time counter.

---
 rtl/game_timer_pkg.sv | 32 +++
 rtl/tick_prescaler.sv | 35 +++
 rtl/game_tick_timer.sv | 143 ++++++++++++++
 tb/tb_game_tick_timer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the game tick timer and its prescaler.
// Holds the state encoding, the prescaler width calculation and a load-time BCD converter.
package game_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Bits needed to hold DIV-1; never narrower than one bit.
    function automatic int div_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

    // Repeated subtraction keeps this a chain of comparators rather than a divider.
    function automatic logic [7:0] bin2bcd(input logic [31:0] v);
        logic [31:0] r;
        logic [3:0]  t;
        r = v;
        t = '0;
        for (int i = 0; i < 9; i++) begin
            if (r >= 32'd10) begin
                r = r - 32'd10;
                t = t + 4'd1;
            end
        end
        return {t, r[3:0]};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Reloadable down-counter: zero is high for the cycle the count sits at 0.
// It reloads DIV-1 on load, or on the cycle it is enabled while at zero.
module tick_prescaler
    import game_timer_pkg::*;
#(
    parameter int DIV = 10
) (
    input  logic clock,
    input  logic resetn,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam int W = div_w(DIV);
    localparam logic [W-1:0] RELOAD = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign zero = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = RELOAD;
        else if (en)
            cnt_d = zero ? RELOAD : cnt_q - W'(1);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) cnt_q <= RELOAD;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_tick_timer.sv
// Tick generator and up/down game timer with a registered BCD copy of the count.
// The prescaler only advances while running and not paused, so a pause shifts every later tick.
module game_tick_timer
    import game_timer_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int CNT_W     = 7,
    parameter int MAX_COUNT = 99,
    parameter int WRAP      = 1
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             mode_down,
    input  logic [CNT_W-1:0] load_val,
    output logic             tick,
    output logic [CNT_W-1:0] count,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_ones,
    output logic             running,
    output logic             done
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_COUNT);

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] count_q, count_d, ld_val;
    logic [3:0]       tens_q, tens_d, ones_q, ones_d;
    logic             tick_q, tick_d, running_q, running_d, done_q, done_d;
    logic             active, launch, presc_en, presc_zero, tick_ev, finish;
    logic [7:0]       ld_bcd;

    assign active   = (state_q == S_RUN) || (state_q == S_PAUSE);
    assign launch   = !clear && start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign presc_en = active && !clear && !pause;
    assign tick_ev  = presc_en && presc_zero;
    assign ld_val   = (load_val > MAXC) ? MAXC : load_val;
    assign ld_bcd   = bin2bcd(32'(ld_val));
    // Final tick: down reaching 0, or non-wrapping up reaching MAX_COUNT.
    assign finish   = mode_q ? (count_q == CNT_W'(1))
                             : ((WRAP == 0) && (count_q == MAXC - CNT_W'(1)));

    tick_prescaler #(.DIV(DIV)) u_presc (
        .clock  (clock),
        .resetn (resetn),
        .load   (clear || launch),
        .en     (presc_en),
        .zero   (presc_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE:
                    if (start) state_d = (mode_down && ld_val == '0) ? S_DONE : S_RUN;
                S_RUN:
                    if (pause)                state_d = S_PAUSE;
                    else if (tick_ev && finish) state_d = S_DONE;
                S_PAUSE:
                    if (!pause) state_d = (tick_ev && finish) ? S_DONE : S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_comb begin
        count_d = count_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        mode_d  = mode_q;
        tick_d  = tick_ev;
        if (clear) begin
            count_d = '0;
            tens_d  = '0;
            ones_d  = '0;
        end else if (launch) begin
            mode_d  = mode_down;
            count_d = mode_down ? ld_val : '0;
            tens_d  = mode_down ? ld_bcd[7:4] : 4'd0;
            ones_d  = mode_down ? ld_bcd[3:0] : 4'd0;
        end else if (tick_ev) begin
            if (mode_q) begin
                count_d = count_q - CNT_W'(1);
                ones_d  = (ones_q == 4'd0) ? 4'd9 : ones_q - 4'd1;
                tens_d  = (ones_q == 4'd0) ? tens_q - 4'd1 : tens_q;
            end else if (count_q == MAXC) begin
                count_d = '0;
                tens_d  = '0;
                ones_d  = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
                ones_d  = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
                tens_d  = (ones_q == 4'd9) ? tens_q + 4'd1 : tens_q;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q   <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            mode_q    <= 1'b0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            mode_q    <= mode_d;
            tick_q    <= tick_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign tick     = tick_q;
    assign count    = count_q;
    assign bcd_tens = tens_q;
    assign bcd_ones = ones_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_game_tick_timer.sv
// Scoreboard bench for game_tick_timer: DIV=10, MAX_COUNT=12, one wrapping and one stopping instance.
// Stimulus queues expected ticks and state snapshots; one monitor compares them at the falling edge.
module tb_game_tick_timer;

    typedef struct {
        int e;
        int k;
        int c;
        int t;
        int o;
        int r;
        int d;
    } exp_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0, mode_down = 1'b0;
    logic [6:0] load_val = '0;
    logic       probe = 1'b0;
    int         pkind = 0;
    int         edge_n = 0;
    int         checks = 0;
    int         errors = 0;

    logic [1:0]       tk, rn, dn;
    logic [1:0][6:0]  cn;
    logic [1:0][3:0]  bt, bo;

    exp_t tq0[$];
    exp_t tq1[$];
    exp_t sq[$];

    always #5 clock = ~clock;
    always @(posedge clock) edge_n <= edge_n + 1;

    game_tick_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(7), .MAX_COUNT(12), .WRAP(0)) u_stop (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause), .clear(clear),
        .mode_down(mode_down), .load_val(load_val), .tick(tk[0]), .count(cn[0]),
        .bcd_tens(bt[0]), .bcd_ones(bo[0]), .running(rn[0]), .done(dn[0]));

    game_tick_timer #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(7), .MAX_COUNT(12), .WRAP(1)) u_wrap (
        .clock(clock), .resetn(resetn), .start(start), .pause(pause), .clear(clear),
        .mode_down(mode_down), .load_val(load_val), .tick(tk[1]), .count(cn[1]),
        .bcd_tens(bt[1]), .bcd_ones(bo[1]), .running(rn[1]), .done(dn[1]));

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
        end
    endtask

    task automatic cmp_dut(input string tag, input exp_t x);
        cmp($sformatf("%s dut%0d count", tag, x.k), int'(cn[x.k]), x.c);
        cmp($sformatf("%s dut%0d tens", tag, x.k), int'(bt[x.k]), x.t);
        cmp($sformatf("%s dut%0d ones", tag, x.k), int'(bo[x.k]), x.o);
        cmp($sformatf("%s dut%0d running", tag, x.k), int'(rn[x.k]), x.r);
        cmp($sformatf("%s dut%0d done", tag, x.k), int'(dn[x.k]), x.d);
    endtask

    always @(negedge clock or posedge probe) begin
        exp_t x;
        if (probe) begin
            if (pkind == 0) begin
                for (int k = 0; k < 2; k++) begin
                    x = '{0, k, 0, 0, 0, 0, 0};
                    cmp_dut("reset", x);
                    cmp($sformatf("reset dut%0d tick", k), int'(tk[k]), 0);
                end
            end else begin
                cmp("leftover ticks dut0", tq0.size(), 0);
                cmp("leftover ticks dut1", tq1.size(), 0);
                cmp("leftover state checks", sq.size(), 0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (tk[k]) begin
                    if ((k == 0 && tq0.size() == 0) || (k == 1 && tq1.size() == 0)) begin
                        cmp($sformatf("unexpected tick dut%0d", k), 1, 0);
                    end else begin
                        if (k == 0) x = tq0.pop_front();
                        else        x = tq1.pop_front();
                        cmp($sformatf("tick edge dut%0d", k), edge_n, x.e);
                        cmp_dut("tick", x);
                    end
                end
            end
            while (sq.size() > 0 && sq[0].e <= edge_n) begin
                x = sq.pop_front();
                cmp($sformatf("state edge dut%0d", x.k), edge_n, x.e);
                cmp_dut("state", x);
            end
        end
    end

    function automatic exp_t mk(input int k, input int e, input int c, input int r, input int d);
        exp_t x;
        x = '{e, k, c, c / 10, c % 10, r, d};
        return x;
    endfunction

    task automatic tick_exp(input int k, input int e, input int c, input int r, input int d);
        if (k == 0) tq0.push_back(mk(0, e, c, r, d));
        else        tq1.push_back(mk(1, e, c, r, d));
    endtask

    task automatic tick_both(input int e, input int c);
        tick_exp(0, e, c, 1, 0);
        tick_exp(1, e, c, 1, 0);
    endtask

    task automatic st_both(input int e, input int c, input int r, input int d);
        sq.push_back(mk(0, e, c, r, d));
        sq.push_back(mk(1, e, c, r, d));
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) @(negedge clock);
    endtask

    // Start pulse sampled at edge s0; returns at the falling edge after it.
    task automatic go(input logic md, input int lv, output int s0);
        start = 1'b1;
        mode_down = md;
        load_val = 7'(lv);
        s0 = edge_n + 1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic clr();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        st_both(edge_n + 1, 0, 0, 0);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1);
    end

    initial begin
        int s0, s1;
        #3;
        pkind = 0; probe = 1'b1; #1 probe = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Up run: ticks at 10/20/30
        go(1'b0, 0, s0);
        st_both(s0 + 1, 0, 1, 0);
        for (int i = 1; i <= 3; i++) tick_both(s0 + 10 * i, i);
        wait_edge(s0 + 32);
        clr();

        // Wrap vs stop at MAX_COUNT
        go(1'b0, 0, s0);
        for (int i = 1; i <= 14; i++) tick_exp(1, s0 + 10 * i, i % 13, 1, 0);
        for (int i = 1; i <= 12; i++) tick_exp(0, s0 + 10 * i, i, (i == 12) ? 0 : 1, (i == 12) ? 1 : 0);
        wait_edge(s0 + 145);
        sq.push_back(mk(0, s0 + 146, 12, 0, 1));
        sq.push_back(mk(1, s0 + 146, 1, 1, 0));
        wait_edge(s0 + 147);
        clr();

        // Down run from 3, then restart from DONE with a clamped load
        go(1'b1, 3, s0);
        st_both(s0 + 1, 3, 1, 0);
        tick_both(s0 + 10, 2);
        tick_both(s0 + 20, 1);
        tick_exp(0, s0 + 30, 0, 0, 1);
        tick_exp(1, s0 + 30, 0, 0, 1);
        wait_edge(s0 + 44);
        st_both(s0 + 45, 0, 0, 1);
        wait_edge(s0 + 46);
        go(1'b1, 50, s1);
        st_both(s1 + 1, 12, 1, 0);
        tick_both(s1 + 10, 11);
        tick_both(s1 + 20, 10);
        tick_both(s1 + 30, 9);
        wait_edge(s1 + 33);
        clr();

        // Pause for 7 cycles from cycle 5, then a pause that swallows a due tick
        go(1'b0, 0, s0);
        tick_both(s0 + 17, 1);
        tick_both(s0 + 27, 2);
        tick_both(s0 + 40, 3);
        tick_both(s0 + 50, 4);
        wait_edge(s0 + 4);
        pause = 1'b1;
        st_both(s0 + 6, 0, 0, 0);
        repeat (7) @(negedge clock);
        pause = 1'b0;
        wait_edge(s0 + 36);
        pause = 1'b1;
        st_both(s0 + 38, 2, 0, 0);
        repeat (3) @(negedge clock);
        pause = 1'b0;
        wait_edge(s0 + 52);
        clr();

        // Priority: start ignored in RUN, clear beats start, down from 0 ends at once
        go(1'b0, 0, s0);
        tick_both(s0 + 10, 1);
        tick_both(s0 + 20, 2);
        wait_edge(s0 + 14);
        start = 1'b1; mode_down = 1'b1; load_val = 7'd5;
        @(negedge clock);
        start = 1'b0; mode_down = 1'b0;
        wait_edge(s0 + 24);
        clear = 1'b1; start = 1'b1;
        @(negedge clock);
        clear = 1'b0; start = 1'b0;
        st_both(s0 + 26, 0, 0, 0);
        wait_edge(s0 + 31);
        go(1'b1, 0, s1);
        st_both(s1 + 1, 0, 0, 1);
        wait_edge(s1 + 25);
        clr();

        // Asynchronous reset mid-run at count 5
        go(1'b0, 0, s0);
        for (int i = 1; i <= 5; i++) tick_both(s0 + 10 * i, i);
        wait_edge(s0 + 52);
        st_both(s0 + 53, 5, 1, 0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1 pkind = 0; probe = 1'b1;
        #1 probe = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        repeat (3) @(negedge clock);

        pkind = 1; probe = 1'b1;
        #1 probe = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
